wb_stage: RTL and testbench

Write-back stage of the five-instruction-class RV64 core. It sits at the consuming end of the execute stage's result interface. It accepts one result per handshake, resolves loads by waiting for the memory read response, then sign- or zero-extends the returned data. It drives the single register-file write port and keeps a 64-bit retired-instruction counter.

---
 rtl/wb_stage_if.sv | 28 ++
 rtl/wb_stage.sv | 124 ++++++++++++
 tb/tb_wb_stage.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// Result and load-response bundle between execute/memory and write-back.
// The master drives results and load data; write-back (slave) returns exe_ready.
interface wb_stage_if #(
    parameter int XLEN = 64
);
    logic            exe_valid;
    logic            exe_ready;
    logic [XLEN-1:0] exe_rd_data;
    logic [4:0]      exe_rd_addr;
    logic            exe_rd_wen;
    logic            exe_is_load;
    logic [2:0]      exe_load_op;
    logic [2:0]      exe_addr_lo;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output exe_valid, exe_rd_data, exe_rd_addr, exe_rd_wen, exe_is_load,
               exe_load_op, exe_addr_lo, mem_rvalid, mem_rdata,
        input  exe_ready
    );

    modport slave (
        input  exe_valid, exe_rd_data, exe_rd_addr, exe_rd_wen, exe_is_load,
               exe_load_op, exe_addr_lo, mem_rvalid, mem_rdata,
        output exe_ready
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: one-entry holding buffer, load-data extraction/extension,
// register-file write port and retired-instruction counter.
//
// state       | meaning
// ------------+-----------------------------------------------
// ST_IDLE     | entry empty, ready for a result
// ST_HOLD     | entry valid, retires (writes rf) this cycle
// ST_WAIT_MEM | load accepted, waiting for mem_rvalid
module wb_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    wb_stage_if.slave       exe,
    output logic            rf_wen,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [63:0]     instret
);
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOLD     = 2'd1,
        ST_WAIT_MEM = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [4:0]      addr_q, addr_d;
    logic            wen_q, wen_d;
    logic [2:0]      load_op_q, load_op_d;
    logic [2:0]      addr_lo_q, addr_lo_d;
    logic [63:0]     instret_q, instret_d;

    logic            ready;
    logic            accept;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [31:0]     word_sel;
    logic [XLEN-1:0] load_ext;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            load_op_q <= '0;
            addr_lo_q <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            wen_q     <= wen_d;
            load_op_q <= load_op_d;
            addr_lo_q <= addr_lo_d;
            instret_q <= instret_d;
        end
    end

    // Lane selection ignores the low address bits below the access size.
    assign byte_sel = exe.mem_rdata[{addr_lo_q, 3'b000} +: 8];
    assign half_sel = exe.mem_rdata[{addr_lo_q[2:1], 4'b0000} +: 16];
    assign word_sel = exe.mem_rdata[{addr_lo_q[2], 5'b00000} +: 32];

    always_comb begin
        load_ext = '0;
        case (load_op_q)
            3'b000:  load_ext = {{56{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{48{half_sel[15]}}, half_sel};
            3'b010:  load_ext = {{32{word_sel[31]}}, word_sel};
            3'b011:  load_ext = exe.mem_rdata;
            3'b100:  load_ext = {56'd0, byte_sel};
            3'b101:  load_ext = {48'd0, half_sel};
            3'b110:  load_ext = {32'd0, word_sel};
            default: load_ext = '0;
        endcase
    end

    assign accept = exe.exe_valid && ready;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        addr_d    = addr_q;
        wen_d     = wen_q;
        load_op_d = load_op_q;
        addr_lo_d = addr_lo_q;
        instret_d = (state_q == ST_HOLD) ? instret_q + 64'd1 : instret_q;

        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (accept) begin
                    state_d   = exe.exe_is_load ? ST_WAIT_MEM : ST_HOLD;
                    data_d    = exe.exe_is_load ? '0 : exe.exe_rd_data;
                    addr_d    = exe.exe_rd_addr;
                    wen_d     = exe.exe_rd_wen;
                    load_op_d = exe.exe_load_op;
                    addr_lo_d = exe.exe_addr_lo;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_MEM: begin
                if (exe.mem_rvalid) begin
                    state_d = ST_HOLD;
                    data_d  = load_ext;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Both handshake and write are held off while reset is asserted.
    always_comb begin
        ready  = rst && (state_q != ST_WAIT_MEM);
        rf_wen = rst && (state_q == ST_HOLD) && wen_q && (addr_q != 5'd0);
    end

    assign exe.exe_ready = ready;
    assign rf_waddr      = addr_q;
    assign rf_wdata      = data_q;
    assign instret       = instret_q;
endmodule

// File: tb/tb_wb_stage.sv
// Directed plus randomized bench for wb_stage; load results come from an
// arithmetic reference of the load rules, retire count from a bench counter.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [63:0] instret;

    wb_stage_if #(.XLEN(64)) bus ();

    wb_stage #(.XLEN(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .exe      (bus.slave),
        .rf_wen   (rf_wen),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .instret  (instret)
    );

    always #5 clk = ~clk;

    int          n_asserts = 0;
    int          n_fail    = 0;
    logic [63:0] exp_instret;

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Load result from the ISA rules: size, aligned offset, optional sign fill.
    function automatic logic [63:0] ext_model(input logic [2:0] op, input logic [2:0] lo,
                                              input logic [63:0] d);
        int          nbytes;
        bit          sgn;
        int          off;
        logic [63:0] v;
        logic [63:0] mask;
        case (op)
            3'd0: begin nbytes = 1; sgn = 1; end
            3'd1: begin nbytes = 2; sgn = 1; end
            3'd2: begin nbytes = 4; sgn = 1; end
            3'd3: begin nbytes = 8; sgn = 0; end
            3'd4: begin nbytes = 1; sgn = 0; end
            3'd5: begin nbytes = 2; sgn = 0; end
            3'd6: begin nbytes = 4; sgn = 0; end
            default: return 64'd0;
        endcase
        off = (int'(lo) / nbytes) * nbytes;
        v   = d >> (8 * off);
        if (nbytes < 8) begin
            mask = (64'd1 << (8 * nbytes)) - 64'd1;
            v    = v & mask;
            if (sgn && v[8 * nbytes - 1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive_alu(input logic [4:0] a, input logic [63:0] d, input logic w);
        bus.exe_valid   = 1'b1;
        bus.exe_is_load = 1'b0;
        bus.exe_rd_addr = a;
        bus.exe_rd_data = d;
        bus.exe_rd_wen  = w;
        bus.exe_load_op = 3'($urandom);
        bus.exe_addr_lo = 3'($urandom);
    endtask

    task automatic drive_load(input logic [4:0] a, input logic [2:0] op, input logic [2:0] lo,
                              input logic w);
        bus.exe_valid   = 1'b1;
        bus.exe_is_load = 1'b1;
        bus.exe_rd_addr = a;
        bus.exe_rd_data = rnd64();
        bus.exe_rd_wen  = w;
        bus.exe_load_op = op;
        bus.exe_addr_lo = lo;
    endtask

    // Called at the negedge of a cycle in which the entry should be retiring.
    task automatic check_retire(input string tag, input logic [4:0] a, input logic [63:0] d,
                                input logic w);
        logic exp_wen;
        exp_wen = w && (a != 5'd0);
        chk({tag, "_wen"}, rf_wen, exp_wen);
        chk({tag, "_ready"}, bus.exe_ready, 1'b1);
        if (exp_wen) begin
            chk({tag, "_waddr"}, rf_waddr, a);
            chk({tag, "_wdata"}, rf_wdata, d);
        end
    endtask

    task automatic do_alu(input string tag, input logic [4:0] a, input logic [63:0] d,
                          input logic w);
        drive_alu(a, d, w);
        next_edge();
        bus.exe_valid = 1'b0;
        mid();
        check_retire(tag, a, d, w);
        next_edge();
        exp_instret++;
        mid();
        chk({tag, "_instret"}, instret, exp_instret);
        chk({tag, "_idle_wen"}, rf_wen, 1'b0);
    endtask

    // Entered #1 after the edge that accepted the load.
    task automatic load_tail(input string tag, input logic [4:0] a, input logic [2:0] op,
                             input logic [2:0] lo, input logic [63:0] rd, input int delay,
                             input logic w);
        bus.exe_valid  = 1'b0;
        bus.mem_rvalid = 1'b0;
        repeat (delay) begin
            mid();
            chk({tag, "_wait_ready"}, bus.exe_ready, 1'b0);
            chk({tag, "_wait_wen"}, rf_wen, 1'b0);
            next_edge();
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rd;
        mid();
        chk({tag, "_rsp_ready"}, bus.exe_ready, 1'b0);
        next_edge();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = rnd64();
        mid();
        check_retire(tag, a, ext_model(op, lo, rd), w);
        next_edge();
        exp_instret++;
        mid();
        chk({tag, "_instret"}, instret, exp_instret);
    endtask

    task automatic do_load(input string tag, input logic [4:0] a, input logic [2:0] op,
                           input logic [2:0] lo, input logic [63:0] rd, input int delay,
                           input logic w);
        drive_load(a, op, lo, w);
        // A response in the accept cycle must not be captured.
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = ~rd;
        next_edge();
        load_tail(tag, a, op, lo, rd, delay, w);
    endtask

    initial begin
        logic [63:0] d0;
        logic [63:0] d1;
        rst             = 1'b0;
        bus.exe_valid   = 1'b0;
        bus.exe_is_load = 1'b0;
        bus.exe_rd_addr = '0;
        bus.exe_rd_data = '0;
        bus.exe_rd_wen  = 1'b0;
        bus.exe_load_op = '0;
        bus.exe_addr_lo = '0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = '0;
        exp_instret     = 64'd0;

        repeat (2) next_edge();
        mid();
        chk("rst_ready_low", bus.exe_ready, 1'b0);
        chk("rst_wen", rf_wen, 1'b0);
        chk("rst_waddr", rf_waddr, 5'd0);
        chk("rst_wdata", rf_wdata, 64'd0);
        chk("rst_instret", instret, 64'd0);
        rst = 1'b1;
        next_edge();
        mid();
        chk("post_rst_ready", bus.exe_ready, 1'b1);
        chk("post_rst_wen", rf_wen, 1'b0);

        // Three back-to-back non-loads.
        drive_alu(5'd5, 64'h11, 1'b1);
        next_edge();
        drive_alu(5'd6, 64'h22, 1'b1);
        mid();
        check_retire("b2b0", 5'd5, 64'h11, 1'b1);
        next_edge();
        exp_instret++;
        drive_alu(5'd7, 64'h33, 1'b1);
        mid();
        check_retire("b2b1", 5'd6, 64'h22, 1'b1);
        chk("b2b1_instret", instret, exp_instret);
        next_edge();
        exp_instret++;
        bus.exe_valid = 1'b0;
        mid();
        check_retire("b2b2", 5'd7, 64'h33, 1'b1);
        next_edge();
        exp_instret++;
        mid();
        chk("b2b_end_wen", rf_wen, 1'b0);
        chk("b2b_instret3", instret, 64'd3);

        // Load extension on the same doubleword.
        d0 = 64'h0000_0000_8000_0000;
        do_load("lb", 5'd10, 3'b000, 3'd3, d0, 2, 1'b1);
        chk("lb_value", rf_wdata, 64'hFFFF_FFFF_FFFF_FF80);
        do_load("lbu", 5'd11, 3'b100, 3'd3, d0, 1, 1'b1);
        do_load("lhu", 5'd12, 3'b101, 3'd2, d0, 0, 1'b1);
        do_load("lw", 5'd13, 3'b010, 3'd0, d0, 1, 1'b1);
        chk("lw_value", rf_wdata, 64'hFFFF_FFFF_8000_0000);
        do_load("lwu", 5'd14, 3'b110, 3'd0, d0, 3, 1'b1);
        do_load("ld", 5'd15, 3'b011, 3'd5, d0, 1, 1'b1);
        do_load("f111", 5'd16, 3'b111, 3'd1, rnd64(), 1, 1'b1);

        // x0 destination never writes but still counts.
        do_alu("x0_alu", 5'd0, 64'hDEAD_BEEF, 1'b1);
        do_load("x0_load", 5'd0, 3'b011, 3'd0, rnd64(), 2, 1'b1);

        // Load accepted while a non-load is retiring.
        d1 = rnd64();
        drive_alu(5'd9, d1, 1'b1);
        next_edge();
        drive_load(5'd20, 3'b001, 3'd3, 1'b1);
        mid();
        check_retire("hold_ld_alu", 5'd9, d1, 1'b1);
        next_edge();
        exp_instret++;
        load_tail("hold_ld", 5'd20, 3'b001, 3'd3, rnd64(), 1, 1'b1);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 0)
                do_alu("rnd_alu", 5'($urandom), rnd64(), 1'($urandom));
            else
                do_load("rnd_ld", 5'($urandom), 3'($urandom), 3'($urandom), rnd64(),
                        int'($urandom_range(0, 3)), 1'($urandom));
        end

        // Stray response while idle.
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rnd64();
        mid();
        chk("spur_wen", rf_wen, 1'b0);
        chk("spur_ready", bus.exe_ready, 1'b1);
        next_edge();
        bus.mem_rvalid = 1'b0;
        mid();
        chk("spur_wen2", rf_wen, 1'b0);
        chk("spur_instret", instret, exp_instret);

        // Reset while waiting for memory, then a late response.
        drive_load(5'd21, 3'b011, 3'd0, 1'b1);
        next_edge();
        bus.exe_valid = 1'b0;
        mid();
        chk("rw_ready_wait", bus.exe_ready, 1'b0);
        rst = 1'b0;
        next_edge();
        mid();
        chk("rw_ready_in_rst", bus.exe_ready, 1'b0);
        chk("rw_instret_clr", instret, 64'd0);
        chk("rw_wen", rf_wen, 1'b0);
        rst            = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rnd64();
        next_edge();
        bus.mem_rvalid = 1'b0;
        mid();
        chk("rw_late_ready", bus.exe_ready, 1'b1);
        chk("rw_late_wen", rf_wen, 1'b0);
        next_edge();
        mid();
        chk("rw_after_wen", rf_wen, 1'b0);
        chk("rw_after_instret", instret, 64'd0);
        chk("rw_after_wdata", rf_wdata, 64'd0);
        exp_instret = 64'd0;

        // Reset during the retire cycle drops the write.
        drive_alu(5'd3, rnd64(), 1'b1);
        next_edge();
        bus.exe_valid = 1'b0;
        rst = 1'b0;
        mid();
        chk("rh_wen", rf_wen, 1'b0);
        next_edge();
        rst = 1'b1;
        mid();
        chk("rh_instret", instret, 64'd0);
        next_edge();
        mid();
        chk("rh_idle_wen", rf_wen, 1'b0);
        chk("rh_ready", bus.exe_ready, 1'b1);

        // Counter wrap.
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        mid();
        chk("wrap_pre", instret, 64'hFFFF_FFFF_FFFF_FFFF);
        exp_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        do_alu("wrap", 5'd4, rnd64(), 1'b1);
        chk("wrap_zero", instret, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
